// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  // PS/2 uses odd parity: the data bits plus the parity bit hold an odd number of ones.
  function automatic logic parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchroniser and run-length glitch filter for the PS/2 clock line.
// Produces a one-cycle pulse whenever the filtered level falls from 1 to 0.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Flops preset to 1 so an idle (high) line produces no edge when reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: 11-bit LSB-first frames with start, odd parity
// and stop checks, inter-edge timeout, and one-cycle result strobes.
//   state  | meaning
//   IDLE   | waiting for a start bit (data low on a filtered fall)
//   DATA   | shifting in the 8 data bits, LSB first
//   PARITY | waiting for the parity bit
//   STOP   | waiting for the stop bit, then evaluating the frame
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0] LAST_BIT = 4'(PS2_DATA_BITS - 1);

  ps2_rx_state_t            state, state_nxt;
  logic [3:0]               bit_cnt, bit_cnt_nxt;
  logic [PS2_DATA_BITS-1:0] shift, shift_nxt;
  logic                     par_bit, par_bit_nxt;
  logic [TO_W-1:0]          to_cnt, to_cnt_nxt;
  logic [7:0]               data_nxt;
  logic                     valid_nxt, perr_nxt, ferr_nxt;
  logic [1:0]               data_sync;
  logic                     data_bit;
  logic                     fall;
  logic                     timeout;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk_i),
    .rst_n(reset_i),
    .line (ps2_clk_i),
    .fall (fall)
  );

  assign data_bit = data_sync[1];
  assign busy_o   = (state != IDLE);
  assign timeout  = (state != IDLE) && (to_cnt == TO_MAX);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      data_sync    <= 2'b11;
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      to_cnt       <= '0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      data_sync    <= {data_sync[0], ps2_data_i};
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift        <= shift_nxt;
      par_bit      <= par_bit_nxt;
      to_cnt       <= to_cnt_nxt;
      data_o       <= data_nxt;
      valid_o      <= valid_nxt;
      parity_err_o <= perr_nxt;
      frame_err_o  <= ferr_nxt;
    end
  end

  always_comb begin
    if (state == IDLE || fall || timeout) begin
      to_cnt_nxt = '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt_nxt = to_cnt + TO_W'(1);
    end else begin
      to_cnt_nxt = to_cnt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_bit_nxt = par_bit;
    data_nxt    = data_o;
    valid_nxt   = 1'b0;
    perr_nxt    = 1'b0;
    ferr_nxt    = 1'b0;

    if (timeout) begin
      // A fall coinciding with the abort is judged as if the FSM were already idle.
      ferr_nxt    = 1'b1;
      state_nxt   = (fall && !data_bit) ? DATA : IDLE;
      bit_cnt_nxt = '0;
      shift_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall && !data_bit) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
            shift_nxt   = '0;
          end
        end
        DATA: begin
          if (fall) begin
            shift_nxt   = {data_bit, shift[PS2_DATA_BITS-1:1]};
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              state_nxt = PARITY;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            par_bit_nxt = data_bit;
            state_nxt   = STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state_nxt = IDLE;
            if (!data_bit) begin
              ferr_nxt = 1'b1;
            end else if (!parity_ok(shift, par_bit)) begin
              perr_nxt = 1'b1;
            end else begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
